// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM states and operand classification helpers.
package rv32m_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv32m_sign_fix.sv
// Combinational sign handling: operand magnitude extraction and
// conditional two's-complement negation of the 64-bit result value.
module rv32m_sign_fix
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2*XLEN-1:0] val,
  input  logic              val_neg,
  output logic [2*XLEN-1:0] val_out
);

  assign a_neg   = a_signed & a[XLEN-1];
  assign b_neg   = b_signed & b[XLEN-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign val_out = val_neg ? -val : val;

endmodule

// File: rtl/rv32m_muldiv.sv
// RV32M multiply/divide unit: 32-cycle radix-2 shift-add multiply and
// restoring divide behind valid/ready handshakes, with flush abort.
`ifndef RV32M_DEBUG_PRINT
`define RV32M_DEBUG_PRINT(msg)
`endif

module rv32m_muldiv
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  state_t          state_q, state_d;
  logic [4:0]      cnt_q;
  logic [2:0]      op_q;
  logic            res_neg_q;
  logic [XLEN-1:0] x_q;    // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] y_q;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;

  logic            accept;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg, b_neg;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nxt, quo_nxt;
  logic [2*XLEN-1:0] fix_val, fix_out;
  logic [XLEN-1:0]   final_res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE) && !flush;

  rv32m_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .a        (in_a),
    .b        (in_b),
    .a_signed (op_a_signed(in_op)),
    .b_signed (op_b_signed(in_op)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .val      (fix_val),
    .val_neg  (res_neg_q),
    .val_out  (fix_out)
  );

  // Divide-by-zero and signed overflow are answered without iterating.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (in_op[2]) begin
      if (in_b == '0) begin
        special     = 1'b1;
        special_res = in_op[1] ? in_a : ALL_ONES;
      end else if (!in_op[0] && (in_a == DIV_OVF_A) && (in_b == ALL_ONES)) begin
        special     = 1'b1;
        special_res = in_op[1] ? '0 : DIV_OVF_A;
      end
    end
  end

  // Multiply keeps the multiplier in acc_q's low half; each step adds into
  // the high half and shifts the whole accumulator right by one.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, y_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[XLEN-1:0], x_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, y_q};
    q_bit     = ~rem_diff[XLEN];
    rem_nxt   = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_nxt   = {x_q[XLEN-2:0], q_bit};
    if (!op_q[2]) begin
      fix_val = mul_nxt;
    end else if (!op_q[1]) begin
      fix_val = {{XLEN{1'b0}}, quo_nxt};
    end else begin
      fix_val = {{XLEN{1'b0}}, rem_nxt};
    end
    if (op_q[2] || (op_q == OP_MUL)) begin
      final_res = fix_out[XLEN-1:0];
    end else begin
      final_res = fix_out[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : BUSY;
      BUSY:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= '0;
      res_neg_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      out_result <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            `RV32M_DEBUG_PRINT(("rv32m_muldiv accept op=%0d a=%h b=%h", in_op, in_a, in_b))
            op_q      <= in_op;
            cnt_q     <= '0;
            res_neg_q <= (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
            if (in_op[2]) begin
              x_q   <= a_mag;
              y_q   <= b_mag;
              acc_q <= '0;
            end else begin
              x_q   <= '0;
              y_q   <= a_mag;
              acc_q <= {{XLEN{1'b0}}, b_mag};
            end
            if (special) out_result <= special_res;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 5'd1;
          if (op_q[2]) begin
            x_q   <= quo_nxt;
            acc_q <= {{XLEN{1'b0}}, rem_nxt};
          end else begin
            acc_q <= mul_nxt;
          end
          if (cnt_q == 5'd31) begin
            `RV32M_DEBUG_PRINT(("rv32m_muldiv complete result=%h", final_res))
            out_result <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
